// File: rtl/ship_registry_ctrl.sv
// ship_registry_ctrl: battleship fleet store with single-cycle shot resolution.
//   Optional feature macro: SHOT_STATS_EN (adds shot_count_o / hit_count_o).
//   Ports:
//     clk_i, rst_ni          clock, asynchronous active-low reset
//     clear_i                synchronous wipe back to LOAD
//     active_ships_i         ships in play, sampled on start_i
//     load_*_i               cell write (ship, slot, cell) during LOAD
//     start_i                LOAD -> PLAY
//     shot_valid_i/ready_o   shot handshake, shot_cell_i targeted cell
//     result_*_o/ready_i     registered shot result handshake
//     sunk_mask_o, all_sunk_o registered fleet status
//     state_o                00 LOAD, 01 PLAY, 10 RESULT, 11 DONE
module ship_registry_ctrl #(
  parameter int NUM_SHIPS = 5,
  parameter int MAX_LEN = 5,
  parameter int CELL_W = 5,
  localparam int SW = NUM_SHIPS > 1 ? $clog2(NUM_SHIPS) : 1,
  localparam int LW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1,
  localparam int AW = $clog2(NUM_SHIPS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic [AW-1:0]     active_ships_i,
  input  logic              load_valid_i,
  input  logic [SW-1:0]     load_ship_i,
  input  logic [LW-1:0]     load_slot_i,
  input  logic [CELL_W-1:0] load_cell_i,
  input  logic              start_i,
  input  logic              shot_valid_i,
  input  logic [CELL_W-1:0] shot_cell_i,
  output logic              shot_ready_o,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic              result_hit_o,
  output logic              result_sunk_o,
  output logic [SW-1:0]     result_ship_o,
  output logic [NUM_SHIPS-1:0] sunk_mask_o,
  output logic              all_sunk_o,
`ifdef SHOT_STATS_EN
  output logic [7:0]        shot_count_o,
  output logic [7:0]        hit_count_o,
`endif
  output logic [1:0]        state_o
);
  typedef enum logic [1:0] {LOAD = 2'b00, PLAY = 2'b01, RESULT = 2'b10, DONE = 2'b11} state_t;
  state_t state_q, state_d;
  logic [CELL_W-1:0] cells_q [NUM_SHIPS][MAX_LEN];
  logic [CELL_W-1:0] cells_d [NUM_SHIPS][MAX_LEN];
  logic [NUM_SHIPS-1:0] loaded_q, loaded_d, match, zero_after, zero_d, sunk_d;
  logic [AW-1:0] active_q, active_d;
  logic all_d, hit, win_sunk, shot_fire, start_ok, load_ok;
  logic [SW-1:0] win;
  logic res_hit_q, res_sunk_q;
  logic [SW-1:0] res_ship_q;
  logic [NUM_SHIPS-1:0] sunk_mask_q;
  logic all_sunk_q;
  assign shot_fire = state_q == PLAY && shot_valid_i;
  assign start_ok = state_q == LOAD && start_i && active_ships_i != '0;
  assign load_ok = state_q == LOAD && load_valid_i && int'(load_ship_i) < NUM_SHIPS
                   && int'(load_slot_i) < MAX_LEN;
  assign active_d = clear_i ? '0
                  : start_ok ? (int'(active_ships_i) > NUM_SHIPS ? AW'(NUM_SHIPS) : active_ships_i)
                  : active_q;
  // zero_after[i]: ship i would be empty once every slot equal to shot_cell is cleared
  always_comb begin
    match = '0;
    zero_after = '0;
    hit = 1'b0;
    win = '0;
    win_sunk = 1'b0;
    for (int i = 0; i < NUM_SHIPS; i++) begin
      zero_after[i] = 1'b1;
      for (int j = 0; j < MAX_LEN; j++) begin
        if (cells_q[i][j] == shot_cell_i && shot_cell_i != '0 && i < int'(active_q)) match[i] = 1'b1;
        if (cells_q[i][j] != '0 && cells_q[i][j] != shot_cell_i) zero_after[i] = 1'b0;
      end
    end
    // descending scan so the lowest-index matching ship wins
    for (int i = NUM_SHIPS - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = 1'b1;
        win = SW'(i);
        win_sunk = zero_after[i];
      end
    end
  end
  always_comb begin
    cells_d = cells_q;
    loaded_d = loaded_q;
    for (int i = 0; i < NUM_SHIPS; i++) begin
      for (int j = 0; j < MAX_LEN; j++) begin
        if (clear_i) cells_d[i][j] = '0;
        else if (load_ok && int'(load_ship_i) == i && int'(load_slot_i) == j) cells_d[i][j] = load_cell_i;
        else if (shot_fire && hit && int'(win) == i && cells_q[i][j] == shot_cell_i) cells_d[i][j] = '0;
      end
      loaded_d[i] = clear_i ? 1'b0
                  : (load_ok && int'(load_ship_i) == i && load_cell_i != '0) ? 1'b1
                  : loaded_q[i];
    end
  end
  // fleet status from next-state cells so it lands together with result_valid
  always_comb begin
    zero_d = '0;
    sunk_d = '0;
    all_d = active_d != '0;
    for (int i = 0; i < NUM_SHIPS; i++) begin
      zero_d[i] = 1'b1;
      for (int j = 0; j < MAX_LEN; j++) if (cells_d[i][j] != '0) zero_d[i] = 1'b0;
      if (i < int'(active_d)) begin
        sunk_d[i] = loaded_d[i] && zero_d[i];
        if (!zero_d[i]) all_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= LOAD;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = clear_i ? LOAD
            : start_ok ? PLAY
            : shot_fire ? RESULT
            : (state_q == RESULT && result_ready_i) ? (all_sunk_q ? DONE : PLAY)
            : state_q;
  end
  always_comb begin
    shot_ready_o = state_q == PLAY;
    result_valid_o = state_q == RESULT;
    state_o = state_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cells_q <= '{default: '0};
      loaded_q <= '0;
      active_q <= '0;
      sunk_mask_q <= '0;
      all_sunk_q <= 1'b0;
      res_hit_q <= 1'b0;
      res_sunk_q <= 1'b0;
      res_ship_q <= '0;
    end else begin
      cells_q <= cells_d;
      loaded_q <= loaded_d;
      active_q <= active_d;
      sunk_mask_q <= sunk_d;
      all_sunk_q <= all_d;
      if (clear_i) begin
        res_hit_q <= 1'b0;
        res_sunk_q <= 1'b0;
        res_ship_q <= '0;
      end else if (shot_fire) begin
        res_hit_q <= hit;
        res_sunk_q <= hit && win_sunk;
        res_ship_q <= hit ? win : '0;
      end
    end
  end
  assign result_hit_o = res_hit_q;
  assign result_sunk_o = res_sunk_q;
  assign result_ship_o = res_ship_q;
  assign sunk_mask_o = sunk_mask_q;
  assign all_sunk_o = all_sunk_q;
`ifdef SHOT_STATS_EN
  logic [7:0] shot_cnt_q, hit_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shot_cnt_q <= '0;
      hit_cnt_q <= '0;
    end else if (clear_i) begin
      shot_cnt_q <= '0;
      hit_cnt_q <= '0;
    end else if (shot_fire) begin
      if (shot_cnt_q != 8'hff) shot_cnt_q <= shot_cnt_q + 8'd1;
      if (hit && hit_cnt_q != 8'hff) hit_cnt_q <= hit_cnt_q + 8'd1;
    end
  end
  assign shot_count_o = shot_cnt_q;
  assign hit_count_o = hit_cnt_q;
`endif
endmodule
